// File: rtl/bcd_updown_counter_scan.sv
// Multi-decade synchronous BCD up/down counter with parallel load, terminal-count
// pulse and a time-multiplexed common-segment 7-segment scan driver.

module bcd_updown_counter_scan_digit (
  input  logic [3:0] d_i,
  input  logic       up_i,
  input  logic       step_i,
  output logic [3:0] nxt_o,
  output logic       term_o
);
  // term_o: this decade is at its wrap point for the current direction,
  // so a step here also steps the next decade.
  assign term_o = up_i ? (d_i == 4'd9) : (d_i == 4'd0);

  always_comb begin
    nxt_o = d_i;
    if (step_i) begin
      if (term_o) nxt_o = up_i ? 4'd0 : 4'd9;
      else        nxt_o = up_i ? d_i + 4'd1 : d_i - 4'd1;
    end
  end
endmodule

module bcd_updown_counter_scan #(
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  load_err,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [6:0]            seg
);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIGITS-1:0][3:0] cnt_q, cnt_d, nxt, lv;
  logic [DIGITS:0]        step;
  logic [DIGITS-1:0]      term, lv_ok;
  logic                   tc_q, tc_d, lerr_q, lerr_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [3:0]             sel_dig;

  assign lv      = load_val;
  assign step[0] = en;

  // Carry chain is purely combinational: every decade updates on the same edge.
  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
      bcd_updown_counter_scan_digit u_dig (
        .d_i    (cnt_q[k]),
        .up_i   (up),
        .step_i (step[k]),
        .nxt_o  (nxt[k]),
        .term_o (term[k])
      );
      assign step[k+1] = step[k] & term[k];
      assign lv_ok[k]  = (lv[k] <= 4'd9);
    end
  endgenerate

  always_comb begin
    cnt_d  = cnt_q;
    tc_d   = 1'b0;
    lerr_d = 1'b0;
    if (load) begin
      if (&lv_ok) cnt_d  = lv;
      else        lerr_d = 1'b1;
    end else if (en) begin
      cnt_d = nxt;
      tc_d  = step[DIGITS];
    end
  end

  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tc_q   <= 1'b0;
      lerr_q <= 1'b0;
      div_q  <= '0;
      idx_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tc_q   <= tc_d;
      lerr_q <= lerr_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
    end
  end

  always_comb begin
    digit_sel = '0;
    sel_dig   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        digit_sel[k] = 1'b1;
        sel_dig      = cnt_q[k];
      end
    end
  end

  always_comb begin
    case (sel_dig)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
  end

  assign count    = cnt_q;
  assign tc       = tc_q;
  assign load_err = lerr_q;
endmodule

// File: tb/tb_bcd_updown_counter_scan.sv
// Scoreboard bench: an integer-valued reference model predicts each cycle's
// outputs into a queue; a monitor pops and compares after every clock edge.

module tb_bcd_updown_counter_scan;
  localparam int DIGITS   = 3;
  localparam int SCAN_DIV = 2;
  localparam int W        = 4 * DIGITS;
  localparam int MAXV     = 10 ** DIGITS;

  typedef struct {
    logic [W-1:0]      cnt;
    logic              tc;
    logic              lerr;
    logic [DIGITS-1:0] sel;
    logic [6:0]        seg;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset, en, up, load;
  logic [W-1:0]      load_val, count;
  logic              tc, load_err;
  logic [DIGITS-1:0] digit_sel;
  logic [6:0]        seg;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   v = 0;
  int   n = 0;

  bcd_updown_counter_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count), .tc(tc), .load_err(load_err),
    .digit_sel(digit_sel), .seg(seg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int d);
    logic [6:0] t [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    return t[d];
  endfunction

  function automatic int p10(input int k);
    return 10 ** k;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int x);
    logic [W-1:0] r = '0;
    for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((x / p10(k)) % 10);
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [W-1:0] b);
    for (int k = 0; k < DIGITS; k++) if (b[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] b);
    int r = 0;
    for (int k = 0; k < DIGITS; k++) r += int'(b[4*k +: 4]) * p10(k);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  // One clock of stimulus; the model advances in whole integers, not digits.
  task automatic cyc(input logic e, input logic u, input logic l, input logic [W-1:0] lv);
    exp_t x;
    int   idx;
    @(negedge clk);
    reset = 1'b0; en = e; up = u; load = l; load_val = lv;
    x.tc = 1'b0; x.lerr = 1'b0;
    if (l) begin
      if (bcd_ok(lv)) v = from_bcd(lv);
      else            x.lerr = 1'b1;
    end else if (e) begin
      if (u) begin v = (v + 1) % MAXV;        x.tc = (v == 0);        end
      else   begin v = (v + MAXV - 1) % MAXV; x.tc = (v == MAXV - 1); end
    end
    n++;
    idx   = (n / SCAN_DIV) % DIGITS;
    x.cnt = to_bcd(v);
    x.sel = DIGITS'(1) << idx;
    x.seg = glyph((v / p10(idx)) % 10);
    q.push_back(x);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_tc"}, 32'(tc), 32'd0);
    chk({tag, "_lerr"}, 32'(load_err), 32'd0);
    chk({tag, "_sel"}, 32'(digit_sel), 32'd1);
    chk({tag, "_seg"}, 32'(seg), 32'b1111110);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("count", 32'(count), 32'(x.cnt));
        chk("tc", 32'(tc), 32'(x.tc));
        chk("load_err", 32'(load_err), 32'(x.lerr));
        chk("digit_sel", 32'(digit_sel), 32'(x.sel));
        chk("seg", 32'(seg), 32'(x.seg));
      end
    end
  end

  initial begin : driver
    logic [W-1:0] r;
    reset = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
    #1 check_reset_state("reset");
    repeat (2) @(negedge clk);

    // full up-count wrap: 000..999, 000 with tc
    repeat (MAXV + 3) cyc(1, 1, 0, '0);
    // down wrap from 001
    cyc(0, 0, 1, 12'h001);
    repeat (3) cyc(1, 0, 0, '0);
    // load priority over en, then rejected load
    cyc(1, 1, 1, 12'h042);
    cyc(1, 1, 1, 12'h04A);
    cyc(0, 1, 0, '0);
    repeat (5) cyc(0, 1, 0, '0);
    // direction toggling from 050
    cyc(0, 0, 1, 12'h050);
    for (int i = 0; i < 4; i++) cyc(1, (i % 2) == 0, 0, '0);
    // display scan with static count 123
    cyc(0, 0, 1, 12'h123);
    repeat (12) cyc(0, 0, 0, '0);
    // boundary loads: all-nines, then stepping across both edges
    cyc(0, 0, 1, 12'h999);
    cyc(1, 1, 0, '0);
    cyc(1, 0, 0, '0);
    cyc(1, 0, 0, '0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = W'($urandom_range(0, (1 << W) - 1));
      if ($urandom_range(0, 1) == 1) r = to_bcd(int'($urandom_range(0, MAXV - 1)));
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 9) == 0), r);
    end

    // asynchronous reset mid-cycle at count 057 with en high
    cyc(0, 0, 1, 12'h057);
    @(negedge clk);
    en = 1'b1; up = 1'b1; load = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_state("async_reset");
    q.delete();
    v = 0; n = 0;
    @(negedge clk);
    check_reset_state("reset_hold");
    repeat (5) cyc(1, 1, 0, '0);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_updown_counter_scan.md
# bcd_updown_counter_scan

Parametrised synchronous multi-digit BCD up/down counter with parallel load, terminal-count pulse and a time-multiplexed 7-segment display driver. It generalises the team's fixed two-digit 0-99 counter to DIGITS decades. All digits share one clock, with no ripple clocking between decades. It sits between a tick/enable source and the board's common-segment display, and drives one digit at a time.

## Interface
- DIGITS, 2, number of BCD decades; legal range 1..8; count range 0 .. 10^DIGITS-1
- SCAN_DIV, 4, clk cycles each digit stays selected during display scan; legal range >= 1
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high; clock clk
- en  in  1  count enable; one step per clk edge while high
- up  in  1  direction; 1 = increment, 0 = decrement; sampled only when stepping
- load  in  1  synchronous parallel load; priority over en
- load_val  in  4*DIGITS  BCD load value; digit k in bits [4k+3:4k]
- count  out  4*DIGITS  registered BCD count; digit 0 is least significant
- tc  out  1  registered terminal-count pulse, one cycle, on wrap in either direction
- load_err  out  1  registered one-cycle pulse; load rejected because a load_val digit was > 9
- digit_sel  out  DIGITS  one-hot digit enable for display, active-high; bit k selects digit k
- seg  out  7  segments of the selected digit, active-high; seg[6]=a, seg[5]=b ... seg[0]=g

## Operation
- Reset (async assert, any time): count=0, tc=0, load_err=0, scan index=0, divider=0. This gives digit_sel=...0001 and seg=7'b1111110 (glyph 0). Mid-operation reset discards any pending step or load. Release is synchronous to clk; the first action occurs on the first edge with reset low.
- Per-edge priority, highest first: load, then en, then hold.
- Load with all load_val digits 0..9: count <= load_val, tc=0, load_err=0.
- Load with any load_val digit > 9: count holds, load_err=1 for the next cycle, tc=0. en is ignored on that edge.
- en=1, up=1: digit 0 increments. Digit k increments only when digits 0..k-1 are all 9, and a digit at 9 wraps to 0. At the all-9s value, count goes to 0 and tc=1.
- en=1, up=0: digit 0 decrements. Digit k decrements only when digits 0..k-1 are all 0, and a digit at 0 wraps to 9. At the all-0s value, count goes to all 9s and tc=1.
- en=0, load=0: count holds, tc=0, load_err=0.
- tc and load_err are never high in the same cycle.
- Digit stepping is fully synchronous. No decade ever sees a partial carry.
- Display scan is free-running, independent of en and load:
  - The divider counts 0..SCAN_DIV-1.
  - On the edge where the divider is at SCAN_DIV-1, the divider returns to 0 and the scan index advances, wrapping from DIGITS-1 to 0.
  - With DIGITS=1, digit_sel is constantly 1.
- digit_sel is the one-hot decode of the scan index. seg is the combinational 7-segment decode of count digit[scan index]:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Any other value gives 0000000 (blank). This is unreachable in normal operation.

## Timing
- count, tc, load_err: one-cycle latency from the sampling edge. The value is visible immediately after the edge on which en or load was high.
- tc is high exactly during the cycle in which count shows the wrapped value (0 going up, all 9s going down).
- Continuous en=1, up=1: tc period = 10^DIGITS cycles.
- digit_sel and seg change only after clk edges; they are glitch-free with respect to the inputs.
- Each digit is selected for SCAN_DIV consecutive cycles. The full scan period is DIGITS*SCAN_DIV cycles.
- seg follows count within the same cycle when the selected digit's value changes.

## Test plan
- Reset and up-count, DIGITS=2: assert reset, then hold en=1, up=1 for 100 cycles -> count steps 00,01..09,10..99,00; tc=1 only in the cycle count=00 after 99.
- Down-count wrap: load 8'h01, then en=1, up=0 for 2 cycles -> count 00, then 99 with tc=1 in that cycle; next cycle 98 with tc=0.
- Load priority and rejection: load=1, en=1, load_val=8'h42 -> count=42, no step. Then load_val=8'h4A -> count stays 42, load_err=1 for one cycle.
- Hold and direction change: en=0 for 5 cycles -> count frozen, tc=0. Toggle up each cycle with en=1 from 50 -> 51,50,51,50.
- Display scan, DIGITS=3, SCAN_DIV=2, count=123: digit_sel sequence 001,001,010,010,100,100,001...; seg shows 1111001 (3) while 001, 1101101 (2) while 010, 0110000 (1) while 100.
- Reset mid-operation: assert reset asynchronously at count=57 while en=1 -> count=00, digit_sel=01, seg=1111110 immediately, before the next clk edge. Counting resumes from 00 after release.
